// File: rtl/ifetch.sv
// ifetch: 32-bit instruction fetch feeding a halfword prefetch queue.
// Ports: clk, reset (async, active-low); stall, pc_load, pc_target from
//   execute; mem_req, mem_addr, mem_ack, mem_rdata to instruction memory;
//   ins, rdone, ins_pc to decode.
// Optional feature macro: IFETCH_BYPASS_EN forwards the first halfword of
//   an ack straight to decode when the queue is empty.
module ifetch #(
   parameter int            RV       = 32,
   parameter int            QDEPTH   = 4,
   parameter logic [RV-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          pc_load,
   input  logic [RV-1:0] pc_target,
   output logic          mem_req,
   output logic [RV-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [15:0]   ins,
   output logic          rdone,
   output logic [RV-1:0] ins_pc
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] ISSUE_MAX = CW'(QDEPTH - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

   state_t        state;
   logic [RV-1:0] fpc;
   logic [15:0]   q_ins [QDEPTH];
   logic [RV-1:0] q_pc  [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          ack_ok;
   logic          byp;
   logic          pop;
   logic [15:0]   hw0;
   logic [15:0]   hw1;
   logic [RV-1:0] pc0;
   logic [RV-1:0] pc1;
   logic [15:0]   wa_ins;
   logic [RV-1:0] wa_pc;
   logic [1:0]    push_n;
   logic          unused_bits;

   // pc_target[0] is forced to zero on redirect
   assign unused_bits = pc_target[0];

   // an ack only carries usable data in BUSY without a redirect
   assign ack_ok = (state == BUSY) & mem_ack & ~pc_load;

   always_comb begin
      // first useful halfword depends on fetch alignment
      hw0 = fpc[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      pc0 = fpc;
      hw1 = mem_rdata[31:16];
      pc1 = fpc + RV'(2);
   end

`ifdef IFETCH_BYPASS_EN
   assign byp = ack_ok & (count == '0) & ~stall;
`else
   assign byp = 1'b0;
`endif

   assign pop    = (count != '0) & ~stall & ~pc_load;
   assign rdone  = pop | byp;
   assign ins    = byp ? hw0 : q_ins[head];
   assign ins_pc = byp ? pc0 : q_pc[head];

   always_comb begin
      push_n = 2'd0;
      wa_ins = hw0;
      wa_pc  = pc0;
      if (ack_ok) begin
         if (byp) begin
            // hw0 went to decode; only the upper half may remain
            wa_ins = hw1;
            wa_pc  = pc1;
            push_n = fpc[1] ? 2'd0 : 2'd1;
         end else begin
            push_n = fpc[1] ? 2'd1 : 2'd2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_ins[i] <= '0;
            q_pc[i]  <= '0;
         end
      end else if (pc_load) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_n != 2'd0) begin
            q_ins[tail] <= wa_ins;
            q_pc[tail]  <= wa_pc;
         end
         if (push_n == 2'd2) begin
            q_ins[tail + PW'(1)] <= hw1;
            q_pc[tail + PW'(1)]  <= pc1;
         end
         tail  <= tail + PW'(push_n);
         head  <= head + PW'(pop);
         count <= count + CW'(push_n) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= {RESET_PC[RV-1:2], 2'b00};
         fpc      <= RESET_PC;
      end else begin
         if (pc_load)
            fpc <= {pc_target[RV-1:1], 1'b0};
         else if (ack_ok)
            fpc <= fpc + (fpc[1] ? RV'(2) : RV'(4));
         unique case (state)
            IDLE: begin
               // two free slots guarantee a full word always fits
               if (!pc_load && count <= ISSUE_MAX) begin
                  mem_req  <= 1'b1;
                  mem_addr <= {fpc[RV-1:2], 2'b00};
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (pc_load) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // stale word: wait it out, then discard
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scoreboard bench for ifetch.
// Memory model answers each request after a programmable wait.
module tb_ifetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [15:0] ins;
   logic        rdone;
   logic [31:0] ins_pc;

   ifetch #(
      .RV(32),
      .QDEPTH(4),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .pc_load(pc_load),
      .pc_target(pc_target),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .ins(ins),
      .rdone(rdone),
      .ins_pc(ins_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          passed = 0;
   int          fails  = 0;
   int          total  = 0;
   int          lat    = 1;
   int          mcnt   = 0;
   bit          acked;
   bit          lo_arm   = 1'b0;
   bit          lo_fired = 1'b0;
   logic [31:0] lo_target;
   logic [31:0] ack_addr;
   logic        s_rdone;
   logic [15:0] s_ins;
   logic [31:0] s_pc;
   bit          stall_rd;
   int          base;
   logic [31:0] exp_q[$];
   logic [31:0] addr_log[$];

   // memory contents, one halfword per address
   function automatic logic [15:0] hw(input logic [31:0] a);
      case (a)
         32'h0:   return 16'h1111;
         32'h2:   return 16'h2222;
         32'h4:   return 16'h3333;
         32'h6:   return 16'h4444;
         32'h10:  return 16'hAAAA;
         32'h12:  return 16'hBBBB;
         default: return a[15:0] ^ 16'h5A5A;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] pc, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(pc + 32'(2 * i));
   endtask

   task automatic step();
      logic [31:0] p;
      @(negedge clk);
      acked = 1'b0;
      if (mem_req) begin
         if (mcnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = {hw(mem_addr + 32'd2), hw(mem_addr)};
            acked     = 1'b1;
            ack_addr  = mem_addr;
            addr_log.push_back(mem_addr);
            mcnt      = 0;
            if (lo_arm) begin
               pc_load   = 1'b1;
               pc_target = lo_target;
               stall     = 1'b0;
               lo_arm    = 1'b0;
               lo_fired  = 1'b1;
            end
         end else begin
            mcnt++;
         end
      end else begin
         mcnt = 0;
      end
      #1;
      s_rdone = rdone;
      s_ins   = ins;
      s_pc    = ins_pc;
      if (rdone) begin
         if (exp_q.size() == 0) begin
            chk("spurious_rdone", 32'(rdone), 32'd0);
         end else begin
            p = exp_q.pop_front();
            chk("ins", 32'(ins), 32'(hw(p)));
            chk("ins_pc", ins_pc, p);
         end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
   endtask

   task automatic run_until_empty(input string tag, input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      stall     = 1'b0;
      pc_load   = 1'b0;
      pc_target = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      lo_target = '0;
      ack_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_rdone", 32'(rdone), 32'd0);
      chk("rst_ins", 32'(ins), 32'd0);
      chk("rst_ins_pc", ins_pc, 32'd0);

      // reset release and zero-wait streaming
      reset = 1'b1;
      step();
      chk("first_req", 32'(mem_req), 32'd1);
      chk("first_addr", mem_addr, 32'h0);
      push_seq(32'h0, 4);
      run_until_empty("stream_drain", 30);

      // long stall fills the queue and blocks further requests
      stall    = 1'b1;
      stall_rd = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         stall_rd |= s_rdone;
      end
      chk("stall_no_rdone", 32'(stall_rd), 32'd0);
      chk("full_no_req", 32'(mem_req), 32'd0);
      chk("fill_acks", 32'(addr_log.size()), 32'd4);
      chk("addr_1", addr_log[1], 32'h4);
      chk("addr_2", addr_log[2], 32'h8);
      stall = 1'b0;
      push_seq(32'h8, 8);
      run_until_empty("stall_drain", 40);
      stall = 1'b1;

      // redirect while BUSY with slow memory
      pc_load   = 1'b1;
      pc_target = 32'h200;
      step();
      pc_load = 1'b0;
      exp_q.delete();
      lat = 4;
      for (int i = 0; i < 30 && !(mem_req && mem_addr == 32'h200); i++)
         step();
      chk("req_200", mem_addr, 32'h200);
      base      = addr_log.size();
      pc_load   = 1'b1;
      pc_target = 32'h106;
      stall     = 1'b0;
      step();
      chk("load_rdone", 32'(s_rdone), 32'd0);
      pc_load = 1'b0;
      chk("drain_req", 32'(mem_req), 32'd1);
      chk("drain_addr", mem_addr, 32'h200);
      push_seq(32'h106, 4);
      run_until_empty("redir_drain", 100);
      stall = 1'b1;
      chk("stale_ack", addr_log[base], 32'h200);
      chk("redir_ack", addr_log[base+1], 32'h104);
      lat = 1;

      // redirect in the same cycle as an ack, queue non-empty
      pc_load   = 1'b1;
      pc_target = 32'h300;
      step();
      pc_load = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 30 && !(acked && ack_addr == 32'h300); i++)
         step();
      chk("ack_300", ack_addr, 32'h300);
      lo_target = 32'h400;
      lo_arm    = 1'b1;
      for (int i = 0; i < 20 && !lo_fired; i++) step();
      chk("load_ack_fired", 32'(lo_fired), 32'd1);
      chk("load_ack_addr", ack_addr, 32'h304);
      chk("load_ack_rdone", 32'(s_rdone), 32'd0);
      pc_load  = 1'b0;
      lo_fired = 1'b0;
      push_seq(32'h400, 4);
      step();
      chk("flush_rdone", 32'(s_rdone), 32'd0);
      run_until_empty("load_ack_drain", 30);
      stall = 1'b1;

      // reset asserted mid-request
      pc_load   = 1'b1;
      pc_target = 32'h500;
      step();
      pc_load = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 40 && !(mem_req && mem_addr == 32'h504); i++)
         step();
      chk("req_504", mem_addr, 32'h504);
      reset = 1'b0;
      stall = 1'b0;
      #1;
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_rdone", 32'(rdone), 32'd0);
      chk("midrst_addr", mem_addr, 32'h0);
      step();
      step();
      reset = 1'b1;
      base  = addr_log.size();
      push_seq(32'h0, 4);
      run_until_empty("restart_drain", 30);
      stall = 1'b1;
      chk("restart_addr", addr_log[base], 32'h0);

      // first ack into an empty queue at 0x10
      pc_load   = 1'b1;
      pc_target = 32'h10;
      step();
      pc_load = 1'b0;
      stall   = 1'b0;
      exp_q.delete();
      push_seq(32'h10, 4);
      for (int i = 0; i < 30 && !(acked && ack_addr == 32'h10); i++)
         step();
      chk("ack_10", ack_addr, 32'h10);
`ifdef IFETCH_BYPASS_EN
      chk("byp_rdone", 32'(s_rdone), 32'd1);
      chk("byp_ins", 32'(s_ins), 32'h0000AAAA);
      step();
      chk("byp_next_rdone", 32'(s_rdone), 32'd1);
      chk("byp_next_ins", 32'(s_ins), 32'h0000BBBB);
`else
      chk("ack_cycle_rdone", 32'(s_rdone), 32'd0);
      step();
      chk("next_rdone", 32'(s_rdone), 32'd1);
      chk("next_ins", 32'(s_ins), 32'h0000AAAA);
      chk("next_pc", s_pc, 32'h10);
`endif
      run_until_empty("final_drain", 30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch and prefetch queue for the 16-bit compressed-instruction core. The block reads 32-bit words from the instruction memory port and splits them into 16-bit halfwords. It buffers those halfwords in a small queue and presents them one per cycle on `ins`/`rdone` to the decode stage. It also takes redirects from the execute stage and discards any stale fetch that is still in flight.

## Interface
Parameters:
- `RV`, 32, register/address width
- `QDEPTH`, 4, halfword queue entries; power of two, at least 4
- `RESET_PC`, 0, fetch address after reset; halfword aligned

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge
- `reset` input 1: asynchronous, active-low (0 = reset), single clock domain
- `stall` input 1: decode/execute cannot accept an instruction this cycle
- `pc_load` input 1: redirect strobe (branch, jump, trap)
- `pc_target` input RV: redirect address; bit 0 ignored (treated as 0)
- `mem_req` output 1: fetch request
- `mem_addr` output RV: word address, bits [1:0] always 0
- `mem_ack` input 1: request complete; `mem_rdata` valid this cycle
- `mem_rdata` input 32: fetched word; [15:0] at `mem_addr`+0, [31:16] at +2
- `ins` output 16: instruction to decode
- `rdone` output 1: `ins` valid and consumed this cycle
- `ins_pc` output RV: address of `ins`

## Operation
- Internal state:
  - `fpc`: next fetch address, halfword granular
  - queue of QDEPTH entries of {halfword, pc}, with head/tail pointers and a count
  - FSM with three states: IDLE, BUSY, DRAIN
- IDLE:
  - if `count <= QDEPTH-2` and no `pc_load`: assert `mem_req`, drive `mem_addr = {fpc[RV-1:2],2'b00}`, go to BUSY
- BUSY:
  - hold `mem_req`=1 and `mem_addr` stable until `mem_ack`
  - on `mem_ack` with `fpc[1]`=0: push both halfwords, lower first; `fpc += 4`
  - on `mem_ack` with `fpc[1]`=1: push the upper halfword only; `fpc += 2`
  - after `mem_ack`: `mem_req` deasserts for at least one cycle; go to IDLE
- Redirect, `pc_load`=1:
  - queue flushed (count=0) at the next edge
  - `fpc <= {pc_target[RV-1:1],1'b0}`
  - in BUSY without `mem_ack`: go to DRAIN
  - in BUSY with `mem_ack` in the same cycle: discard the data; go to IDLE
- DRAIN:
  - keep `mem_req`=1, address unchanged, until `mem_ack`
  - data discarded; go to IDLE
  - a further `pc_load` in DRAIN only updates `fpc`
- Output:
  - `ins`/`ins_pc` = queue head
  - `rdone = (count!=0) & !stall & !pc_load`
  - head pops on `rdone`
- Simultaneous events:
  - push and pop in the same cycle: count changes by (pushed − 1)
  - `pc_load` overrides everything: no pop, no push
- Full: never overflows. The issue rule reserves 2 free entries, and only one request is outstanding.
- Reset values:
  - `mem_req`=0, `mem_addr`=`{RESET_PC[RV-1:2],2'b00}`
  - `ins`=0, `ins_pc`=0, `rdone`=0
  - count=0, `fpc`=`RESET_PC`, state IDLE
- Reset asserted mid-request: all state returns to reset values immediately, and the pending `mem_ack` is ignored. The memory is required to tolerate `mem_req` dropping.

## Timing
- `mem_req` is registered. First request in the cycle after `reset` deasserts.
- Path from `mem_ack` in cycle N to output:
  - queue written at the end of cycle N
  - `rdone` can be 1 in cycle N+1 at the earliest
- `rdone` is combinational from registered count, `stall` and `pc_load`. No other combinational paths from inputs to outputs.
- With zero-wait memory (ack in the cycle after req), the sustained rate is 2 halfwords per 3 cycles.
- Redirect: first request to the new `fpc` one cycle after `pc_load` (IDLE/BUSY+ack) or one cycle after the drain ack (DRAIN).

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - when count=0 and `mem_ack` arrives in BUSY with `!stall & !pc_load`, the first valid halfword drives `ins`/`ins_pc` with `rdone`=1 in the same cycle
  - only the remaining halfword, if any, is pushed
  - adds a combinational `mem_rdata`→`ins` path
- `IFETCH_BYPASS_EN` undefined: no bypass; minimum latency ack→`rdone` is 1 cycle, as above.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning 0x2222_1111 then 0x4444_3333 -> `ins`/`ins_pc` sequence 0x1111/0, 0x2222/2, 0x3333/4, 0x4444/6; `mem_addr` 0, 4, 8.
- Hold `stall`=1 for 10 cycles -> the queue fills to QDEPTH, `mem_req` stays 0 with count > QDEPTH-2, and no entry is lost after `stall` drops.
- `pc_load` with `pc_target`=0x106 while BUSY, ack delayed 3 cycles -> DRAIN, stale word dropped; next request at 0x104, and only 0x106's halfword (`mem_rdata[31:16]`) appears, `ins_pc`=0x106.
- `pc_load` and `mem_ack` in the same cycle, queue non-empty -> `rdone`=0, acked data dropped, count=0 next cycle.
- Assert `reset`=0 while BUSY -> `mem_req`=0 and `rdone`=0 immediately; after release, fetch restarts at `RESET_PC`.
- With `IFETCH_BYPASS_EN`, empty queue, ack of 0xBBBB_AAAA at `fpc`=0x10 -> `rdone`=1 with `ins`=0xAAAA in the ack cycle; 0xBBBB follows next cycle.
